// File: rtl/div_if.sv
// Handshake bundle for the sequential divider.
//
// Handshake: the master raises start together with sign/a/b. The slave
// accepts them at the first rising clk edge where start=1 and busy=0.
// Inputs are sampled only at that edge. After acceptance busy stays high
// until the result is loaded. Lo/Hi/div_zero update in the same cycle
// that done pulses high for exactly one clock. The slave ignores start
// whenever busy=1, and that includes the final (FINISH) cycle.
interface div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sign;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] Lo;
  logic [WIDTH-1:0] Hi;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, sign, a, b,
    input  Lo, Hi, busy, done, div_zero
  );

  modport slave (
    input  start, sign, a, b,
    output Lo, Hi, busy, done, div_zero
  );
endinterface

// File: rtl/div_seq.sv
// Sequential restoring divider, signed or unsigned.
// It computes one quotient bit per clock, MSB first, and works on operand
// magnitudes. The sign is fixed up once, in the FINISH cycle.
// Division by zero bypasses the iteration: it returns Lo=all ones and
// Hi=dividend, and sets div_zero.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  div_if.slave       bus,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  // quo starts as the dividend magnitude. Its MSB is shifted into the
  // partial remainder each step, and the new quotient bit enters at its LSB.
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] a_raw;
  logic             q_neg;
  logic             r_neg;
  logic             dz;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  assign dbg_state = state;
  assign bus.busy  = (state != S_IDLE);

  // Operand magnitudes at acceptance. The most-negative value maps to
  // 2^(WIDTH-1), which the unsigned datapath handles correctly.
  always_comb begin
    a_mag = bus.a;
    b_mag = bus.b;
    if (bus.sign && bus.a[WIDTH-1]) a_mag = -bus.a;
    if (bus.sign && bus.b[WIDTH-1]) b_mag = -bus.b;
  end

  // One restoring step. The remainder is widened by one bit so that the
  // borrow shows up in the top bit of the difference.
  always_comb begin
    rem_sh  = {rem, quo[WIDTH-1]};
    diff    = rem_sh - {1'b0, dvs};
    rem_nxt = rem_sh[WIDTH-1:0];
    if (!diff[WIDTH]) rem_nxt = diff[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], ~diff[WIDTH]};
  end

  // Control FSM, datapath registers and result registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      quo          <= '0;
      rem          <= '0;
      dvs          <= '0;
      a_raw        <= '0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      dz           <= 1'b0;
      bus.Lo       <= '0;
      bus.Hi       <= '0;
      bus.done     <= 1'b0;
      bus.div_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            quo   <= a_mag;
            rem   <= '0;
            dvs   <= b_mag;
            a_raw <= bus.a;
            q_neg <= bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_neg <= bus.sign & bus.a[WIDTH-1];
            dz    <= (bus.b == '0);
            cnt   <= '0;
            state <= (bus.b == '0) ? S_FINISH : S_CALC;
          end
        end
        S_CALC: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= S_FINISH;
        end
        S_FINISH: begin
          if (dz) begin
            bus.Lo <= '1;
            bus.Hi <= a_raw;
          end else begin
            bus.Lo <= q_neg ? -quo : quo;
            bus.Hi <= r_neg ? -rem : rem;
          end
          bus.div_zero <= dz;
          bus.done     <= 1'b1;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand, quotient and remainder width in bits.
REQ-002 The block SHALL have input clk, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have input reset, 1 bit, synchronous active-low reset: reset=0 sampled at a rising clk edge resets the block.
REQ-004 The block SHALL have input start, 1 bit, which requests a division when high and accepted in IDLE.
REQ-005 The block SHALL have input sign, 1 bit: 1 selects signed two's-complement division, 0 selects unsigned.
REQ-006 The block SHALL have input a, WIDTH bits, the dividend, sampled at acceptance.
REQ-007 The block SHALL have input b, WIDTH bits, the divisor, sampled at acceptance.
REQ-008 The block SHALL have output Lo, WIDTH bits, the quotient (registered).
REQ-009 The block SHALL have output Hi, WIDTH bits, the remainder (registered).
REQ-010 The block SHALL have output busy, 1 bit, high while a division is in progress.
REQ-011 The block SHALL have output done, 1 bit, a one-cycle pulse marking that Hi/Lo were updated.
REQ-012 The block SHALL have output div_zero, 1 bit, registered with done, high when the completed operation had b=0.

Function
REQ-013 The block SHALL implement states IDLE, CALC, FINISH; it SHALL leave reset in IDLE.
REQ-014 In IDLE, start=1 at an edge SHALL latch sign, a and b, compute |a| and |b| when sign=1 (unchanged when sign=0), record quotient sign = a[MSB]^b[MSB] and remainder sign = a[MSB] (both 0 when unsigned), clear the iteration counter, and go to CALC.
REQ-015 In IDLE with start=1 and b=0, the block SHALL go directly to FINISH, skipping CALC.
REQ-016 CALC SHALL perform one restoring shift-subtract step per cycle, MSB of the dividend first: shift the partial remainder left by 1, bring in the next dividend bit, subtract the divisor magnitude if no borrow, and shift the quotient bit in; exactly WIDTH cycles, counter 0..WIDTH-1.
REQ-017 After the step with counter=WIDTH-1, the block SHALL go to FINISH.
REQ-018 In FINISH, the block SHALL load Lo with the quotient (two's-complement negated if the quotient sign is 1) and Hi with the remainder (negated if the remainder sign is 1), pulse done=1 for that one cycle, and return to IDLE.
REQ-019 Latency SHALL be fixed: start accepted at edge N gives done=1 in the cycle following edge N+WIDTH+1 (34 edges inclusive for WIDTH=32); for b=0 the latency SHALL be 2 edges.
REQ-020 busy SHALL be 1 in CALC and FINISH, and 0 in IDLE.
REQ-021 The block SHALL ignore start while busy=1; a, b and sign changes during CALC SHALL NOT affect the result.
REQ-022 For a divide by zero, the block SHALL set Lo=all ones, Hi=a (unmodified dividend) and div_zero=1; these values SHALL hold for both signed and unsigned operation.
REQ-023 For a signed most-negative dividend divided by -1, the block SHALL return Lo=0x80000000 (WIDTH=32) and Hi=0, with no trap or flag.
REQ-024 Results SHALL satisfy a = Lo*b + Hi, with |Hi| < |b| and Hi carrying the sign of a (truncation toward zero).
REQ-025 Hi, Lo and div_zero SHALL hold their last values until the next FINISH.
REQ-026 start=1 in the same cycle as FINISH SHALL NOT be accepted; it SHALL be accepted only in a following IDLE cycle.

Reset
REQ-027 reset=0 at any edge SHALL force state IDLE, counter 0, Lo=0, Hi=0, busy=0, done=0 and div_zero=0, including when reset occurs mid-CALC; the interrupted operation SHALL be discarded with no done pulse.
REQ-028 The first start SHALL be acceptable at the first edge with reset=1.

Verification
REQ-029 The bench SHALL check: unsigned a=100, b=7 -> done after 34 edges with Lo=14, Hi=2, div_zero=0, and busy=1 for exactly 33 cycles.
REQ-030 The bench SHALL check: signed a=-7 (0xFFFFFFF9), b=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1); and signed a=7, b=-2 -> Lo=-3, Hi=1.
REQ-031 The bench SHALL check: a=0x12345678, b=0 (sign=0 and sign=1) -> done at edge 2 with Lo=0xFFFFFFFF, Hi=0x12345678, div_zero=1.
REQ-032 The bench SHALL check: signed a=0x80000000, b=0xFFFFFFFF -> Lo=0x80000000, Hi=0; and unsigned with the same operands -> Lo=0, Hi=0x80000000.
REQ-033 The bench SHALL check: start pulsed with new operands at cycle 10 of a CALC -> ignored, first result correct, no second done.
REQ-034 The bench SHALL check: reset=0 at cycle 15 of a CALC -> the next cycle has busy=0, Lo=Hi=0, and no done; a new start then completes normally.
